// File: rtl/inst_mem_resp.sv
// Instruction-memory responder for the fetch stage: answers each (ce, addr)
// request with the addressed word after a fixed number of wait states.
module inst_mem_resp #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     inst,
  output logic                  inst_valid,
  output logic                  busy,
  output logic                  fault,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // The counter is loaded with one less than the wait count so that it
  // reaches zero in the last busy cycle.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic [3:0]            cnt_nxt;
  logic [DATA_W-1:0]     data_q;
  logic                  fault_q;
  logic                  capture;
  logic                  bad_addr;
  logic [DEPTH_LOG2-1:0] word_idx;

  assign word_idx = addr[DEPTH_LOG2+1:2];
  assign bad_addr = (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != '0);
  assign capture  = ce && ((state == IDLE) || (state == RESP));

  always_ff @(posedge clk) begin
    if (ld_en && !rst) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The word is read at the capture edge, so a loader write in the same
  // cycle or later during WAIT never reaches this fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      fault_q <= 1'b0;
    end else if (capture) begin
      fault_q <= bad_addr;
      data_q  <= bad_addr ? '0 : mem[word_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (ce) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (!ce) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inst_valid = (state == RESP);
    busy       = (state == WAIT);
    fault      = (state == RESP) && fault_q;
    inst       = (state == RESP) ? data_q : '0;
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three instances (0, 2 and 3 wait states) share one
// stimulus stream and are compared against a cycle-arithmetic fetch model.
module tb_inst_mem_resp;

  localparam int NK = 3;
  localparam int WV [NK] = '{0, 2, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [31:0]   inst_o [NK];
  logic [NK-1:0] valid_o;
  logic [NK-1:0] busy_o;
  logic [NK-1:0] fault_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] mmem [1024];
  bit          m_out   [NK];
  int          m_cap   [NK];
  logic [31:0] m_data  [NK];
  bit          m_fault [NK];
  int          cyc = 0;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  inst_mem_resp #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst_o[0]), .inst_valid(valid_o[0]), .busy(busy_o[0]), .fault(fault_o[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_mem_resp #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst_o[1]), .inst_valid(valid_o[1]), .busy(busy_o[1]), .fault(fault_o[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_mem_resp #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst_o[2]), .inst_valid(valid_o[2]), .busy(busy_o[2]), .fault(fault_o[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // A fetch captured in cycle T is busy through T+W and answers in T+1+W;
  // ce low while it is still waiting kills it.
  task automatic modelStep();
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        m_out[k] = 1'b0;
      end else if (m_out[k] && (cyc < m_cap[k] + 1 + WV[k])) begin
        if (!ce) m_out[k] = 1'b0;
      end else if (ce) begin
        m_out[k] = 1'b1;
        m_cap[k] = cyc;
        if ((addr % 4 != 0) || (addr >= 32'd4096)) begin
          m_data[k]  = '0;
          m_fault[k] = 1'b1;
        end else begin
          m_data[k]  = mmem[addr / 4];
          m_fault[k] = 1'b0;
        end
      end else begin
        m_out[k] = 1'b0;
      end
    end
    if (ld_en && !rst) mmem[ld_addr] = ld_data;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input int k, input logic v, input logic b,
                             input logic f, input logic [31:0] i);
    tests++;
    if ({valid_o[k], busy_o[k], fault_o[k], inst_o[k]} !== {v, b, f, i}) begin
      fails++;
      $display("[TB] FAIL %s W=%0d: got valid=%b busy=%b fault=%b inst=%h, want valid=%b busy=%b fault=%b inst=%h",
               name, WV[k], valid_o[k], busy_o[k], fault_o[k], inst_o[k], v, b, f, i);
    end
  endtask

  task automatic checkModel();
    bit v;
    bit b;
    for (int k = 0; k < NK; k++) begin
      v = m_out[k] && (cyc == m_cap[k] + 1 + WV[k]);
      b = m_out[k] && (cyc < m_cap[k] + 1 + WV[k]);
      checkOutput($sformatf("model cyc%0d", cyc), k, v, b, v && m_fault[k], v ? m_data[k] : 32'h0);
    end
  endtask

  task automatic applyStimulus(input logic s_rst, input logic s_ce, input logic [31:0] s_addr,
                               input logic s_ld_en, input logic [9:0] s_ld_addr,
                               input logic [31:0] s_ld_data);
    rst     = s_rst;
    ce      = s_ce;
    addr    = s_addr;
    ld_en   = s_ld_en;
    ld_addr = s_ld_addr;
    ld_data = s_ld_data;
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
  endtask

  task automatic step(input logic s_ce, input logic [31:0] s_addr);
    applyStimulus(1'b0, s_ce, s_addr, 1'b0, 10'd0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] boot [4];
    logic [31:0] a;
    boot = '{32'h24010001, 32'h24020002, 32'h24030003, 32'h24040004};

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 10'd0, 32'h0);
    for (int k = 0; k < NK; k++) checkOutput("reset", k, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 10'(i),
                    (i < 4) ? boot[i] : ((i == 1023) ? 32'h0BADF00D : $urandom));
    end

    vecs.push_back('{1'b1, 32'h0,        1'b0, 10'd0, 32'h0, 1'b1, 32'h24010001, 1'b0});
    vecs.push_back('{1'b1, 32'h4,        1'b0, 10'd0, 32'h0, 1'b1, 32'h24020002, 1'b0});
    vecs.push_back('{1'b1, 32'h8,        1'b0, 10'd0, 32'h0, 1'b1, 32'h24030003, 1'b0});
    vecs.push_back('{1'b1, 32'hC,        1'b0, 10'd0, 32'h0, 1'b1, 32'h24040004, 1'b0});
    vecs.push_back('{1'b1, 32'h6,        1'b0, 10'd0, 32'h0, 1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h1000,     1'b0, 10'd0, 32'h0, 1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'hFFC,      1'b0, 10'd0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b1, 32'h80000000, 1'b0, 10'd0, 32'h0, 1'b1, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 10'd0, 32'h0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h4, 1'b1, 10'd1, 32'hDEADBEEF, 1'b1, 32'h24020002, 1'b0});
    vecs.push_back('{1'b1, 32'h4,        1'b0, 10'd0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 10'd1, 32'h24020002, 1'b0, 32'h0,        1'b0});

    foreach (vecs[n]) begin
      applyStimulus(1'b0, vecs[n].ce, vecs[n].addr, vecs[n].ld_en, vecs[n].ld_addr, vecs[n].ld_data);
      checkOutput($sformatf("vec%0d", n), 0, vecs[n].exp_valid, 1'b0, vecs[n].exp_fault,
                  vecs[n].exp_inst);
    end

    // two wait states, address changes while waiting must be ignored
    idle(5);
    step(1'b1, 32'h4);
    checkOutput("wait2 T+1", 1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h8);
    checkOutput("wait2 T+2", 1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h8);
    checkOutput("wait2 T+3", 1, 1'b1, 1'b0, 1'b0, 32'h24020002);
    step(1'b0, 32'h0);
    checkOutput("wait2 T+4", 1, 1'b0, 1'b0, 1'b0, 32'h0);

    // abort by dropping ce in the first wait cycle
    idle(5);
    step(1'b1, 32'h8);
    checkOutput("abort T+1", 1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0);
    checkOutput("abort T+2", 1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0);
    checkOutput("abort T+3", 1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0);
    checkOutput("abort T+4", 1, 1'b0, 1'b0, 1'b0, 32'h0);

    // reset mid-fetch, with a loader write that reset must suppress
    idle(5);
    step(1'b1, 32'h0);
    step(1'b1, 32'h0);
    checkOutput("rst T+2", 2, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b1, 10'd0, 32'hFFFFFFFF);
    for (int k = 0; k < NK; k++) checkOutput("rst T+3", k, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0);
      checkOutput($sformatf("rst after%0d", i), 2, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    step(1'b1, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("refetch busy%0d", i), 2, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 32'h0);
    end
    checkOutput("refetch busy2", 2, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h0);
    checkOutput("refetch resp", 2, 1'b1, 1'b0, 1'b0, 32'h24010001);
    step(1'b0, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
        1:       a = ($urandom | 32'h1000) & ~32'h3;
        default: a = 32'($urandom_range(0, 1023)) << 2;
      endcase
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, a,
                    $urandom_range(0, 3) == 0, 10'($urandom_range(0, 7)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
Instruction-memory responder on the fetch interface. It sits opposite the PC register and answers each fetch request (ce, pc address) with the instruction word. The memory array holds 2^DEPTH_LOG2 words. A configurable wait-state counter models slow memory; while it runs, a busy signal tells the pipeline to stall. A side loader port fills the array at boot or from the testbench.

Parameters:
ADDR_W, 32, width of the fetch address
DATA_W, 32, instruction word width
DEPTH_LOG2, 10, log2 of the array depth in words (1024 words)
WAIT_CYCLES, 1, wait states per fetch; 0 to 15

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ce  in  1  fetch enable from the PC stage; 1 = request valid
addr  in  ADDR_W  byte address of the requested instruction
inst  out  DATA_W  returned instruction; 0 whenever inst_valid=0
inst_valid  out  1  one-cycle pulse marking inst as valid
busy  out  1  high while a fetch is in its wait states; pipeline stalls
fault  out  1  pulses with inst_valid when the fetch was misaligned or out of range
ld_en  in  1  loader write strobe
ld_addr  in  DEPTH_LOG2  loader word index
ld_data  in  DATA_W  loader write data

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; wait counter is cleared.
  - inst=0, inst_valid=0, busy=0, fault=0.
  - Array contents are NOT cleared.
  - Reset mid-fetch abandons the fetch; no inst_valid is produced for it.
- States:
  - IDLE: no fetch outstanding.
  - WAIT: wait counter running.
  - RESP: inst_valid cycle.
- Capture:
  - In IDLE or RESP with ce=1, addr is sampled at the clock edge (cycle T).
  - The array word is read at T, so the returned data is array content as of T.
- Latency:
  - inst_valid=1 in exactly cycle T+1+WAIT_CYCLES, for one cycle.
  - busy=1 in cycles T+1 .. T+WAIT_CYCLES (registered).
  - With WAIT_CYCLES=0: busy never asserts, and there is one fetch per cycle back-to-back.
- Transitions:
  - IDLE, ce=1: go to WAIT (WAIT_CYCLES>0) or RESP (=0).
  - WAIT: count down; at zero go to RESP.
  - RESP, ce=1: capture a new request in the same cycle and go to WAIT or RESP.
  - RESP, ce=0: go to IDLE.
- Abort: ce=0 in any WAIT cycle returns to IDLE next cycle. busy drops, and no inst_valid is produced.
- Changes on addr during WAIT are ignored.
- Address decode:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Misaligned (addr[1:0]!=0): inst=0 and fault=1 in the response cycle.
  - Out of range (any addr bit above DEPTH_LOG2+1 set): inst=0 and fault=1.
  - The fetch still completes with normal latency.
- Loader:
  - ld_en=1 writes ld_data into word ld_addr at the edge.
  - Writes are allowed in any state and never stall fetches.
  - A same-cycle write and capture to the same word returns the OLD data (read-before-write).
  - A write during WAIT to the captured word is not visible to that fetch.
  - ld_en during rst is ignored.
- ce=0 in IDLE: all outputs stay 0.

Test Plan:
1. WAIT_CYCLES=0; load words 0..3 = 0x24010001, 0x24020002, 0x24030003, 0x24040004. Hold ce=1 and step addr 0,4,8,C on consecutive cycles. Required: inst_valid=1 on 4 consecutive cycles carrying those words in order; busy stays 0.
2. WAIT_CYCLES=2; fetch addr 0x4 at cycle T. Required: busy=1 in T+1 and T+2; inst=0x24020002 with inst_valid=1 only in T+3.
3. WAIT_CYCLES=2; fetch addr 0x8, then drop ce at T+1. Required: busy=0 from T+2; no inst_valid pulse; state IDLE.
4. Fetch addr 0x6, then fetch addr 0x00001000 (DEPTH_LOG2=10). Required: each returns inst=0 with fault=1 and inst_valid=1 at normal latency.
5. WAIT_CYCLES=0; in the same cycle, ld_en writes 0xDEADBEEF to word 1 and ce=1 fetches addr 0x4. Required: the response is 0x24020002; the next fetch of 0x4 returns 0xDEADBEEF.
6. WAIT_CYCLES=3; assert rst at T+2 of a fetch. Required: all outputs 0 the next cycle and no inst_valid. Array contents are preserved: a fetch of 0x0 after reset returns 0x24010001.
